rom_read_arbiter: RTL and testbench



---
 rtl/rom_read_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rom_read_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rom_read_arbiter                                              |
// | Purpose  : Round-robin burst read arbiter sharing a 1-cycle mask ROM      |
// |            between two requesters, with a 2-entry response buffer.       |
// | Options  : ROM_OOB_ERR_EN - out-of-range requests return err beats.       |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module rom_read_arbiter #(
  parameter int unsigned       ROM_WORDS = 2048,
  parameter int unsigned       ROM_AW    = 11,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] ROM_BASE  = 32'h0001_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [2:0]        req0_len,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [2:0]        req1_len,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [31:0]       resp0_data,
  output logic              resp0_last,
  output logic              resp0_err,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [31:0]       resp1_data,
  output logic              resp1_last,
  output logic              resp1_err,
  output logic              rom_me,
  output logic              rom_oe,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [31:0]       rom_q
);

  localparam logic [0:0]        c_IDLE  = 1'b0;
  localparam logic [0:0]        c_BURST = 1'b1;
  localparam logic [ROM_AW-1:0] c_TOP   = ROM_AW'(ROM_WORDS - 1);

  logic [0:0]        r_state;
  logic              r_last_port;
  logic              r_owner;
  logic [ROM_AW-1:0] r_index;
  logic [3:0]        r_beats;
  logic              r_oob;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_inflight_err;
  logic [31:0]       r_data [2];
  logic [1:0]        r_flag_last;
  logic [1:0]        r_flag_err;
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_idle_free;
  logic              w_sel0;
  logic              w_sel1;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_len;
  logic [ROM_AW-1:0] w_idx;
  logic              w_oob_req;
  logic              w_head_valid;
  logic              w_pop;
  logic              w_issue;
  logic [1:0]        w_count_next;

  // New bursts start only when the previous one has fully drained.
  assign w_idle_free = (r_state == c_IDLE) && (r_count == 2'd0) && !r_inflight;
  assign w_sel1      = req1_valid && (!req0_valid || !r_last_port);
  assign w_sel0      = req0_valid && !w_sel1;
  assign req0_ready  = w_idle_free && w_sel0;
  assign req1_ready  = w_idle_free && w_sel1;
  assign w_accept    = w_idle_free && (req0_valid || req1_valid);
  assign w_addr      = w_sel1 ? req1_addr : req0_addr;
  assign w_len       = w_sel1 ? req1_len  : req0_len;
  assign w_idx       = ROM_AW'((w_addr - ROM_BASE) >> 2);

`ifdef ROM_OOB_ERR_EN
  assign w_oob_req = (w_addr < ROM_BASE) ||
                     ({1'b0, w_addr} >= ({1'b0, ROM_BASE} + (ADDR_W+1)'(4 * ROM_WORDS)));
`else
  assign w_oob_req = 1'b0;
`endif

  assign w_head_valid = (r_state == c_BURST) && (r_count != 2'd0);
  assign w_pop        = w_head_valid && (r_owner ? resp1_ready : resp0_ready);

  // Counting the same-cycle pop as free space keeps one word per cycle flowing.
  assign w_issue = (r_state == c_BURST) && (r_beats != 4'd0) &&
                   ((2'(r_inflight) + r_count - 2'(w_pop)) < 2'd2);

  assign rom_me       = w_issue && !r_oob;
  assign rom_oe       = r_inflight && !r_inflight_err;
  assign rom_address  = r_index;
  assign w_count_next = r_count + 2'(r_inflight) - 2'(w_pop);

  assign resp0_valid = w_head_valid && !r_owner;
  assign resp1_valid = w_head_valid &&  r_owner;
  assign resp0_data  = resp0_valid ? r_data[r_rptr] : 32'd0;
  assign resp1_data  = resp1_valid ? r_data[r_rptr] : 32'd0;
  assign resp0_last  = resp0_valid && r_flag_last[r_rptr];
  assign resp1_last  = resp1_valid && r_flag_last[r_rptr];
  assign resp0_err   = resp0_valid && r_flag_err[r_rptr];
  assign resp1_err   = resp1_valid && r_flag_err[r_rptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= c_IDLE;
      r_last_port     <= 1'b1;
      r_owner         <= 1'b0;
      r_index         <= '0;
      r_beats         <= 4'd0;
      r_oob           <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_inflight_err  <= 1'b0;
      for (int i = 0; i < 2; i++) r_data[i] <= 32'd0;
      r_flag_last     <= 2'b00;
      r_flag_err      <= 2'b00;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      if (w_accept) begin
        r_state     <= c_BURST;
        r_owner     <= w_sel1;
        r_last_port <= w_sel1;
        r_index     <= w_idx;
        r_beats     <= 4'(w_len) + 4'd1;
        r_oob       <= w_oob_req;
      end else if ((r_state == c_BURST) && (r_beats == 4'd0) && !r_inflight &&
                   (w_count_next == 2'd0)) begin
        r_state <= c_IDLE;
      end

      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_beats == 4'd1);
      r_inflight_err  <= w_issue && r_oob;
      if (w_issue) begin
        r_index <= (r_index == c_TOP) ? '0 : r_index + ROM_AW'(1);
        r_beats <= r_beats - 4'd1;
      end

      if (r_inflight) begin
        r_data[r_wptr]      <= r_inflight_err ? 32'd0 : rom_q;
        r_flag_last[r_wptr] <= r_inflight_last;
        r_flag_err[r_wptr]  <= r_inflight_err;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= w_count_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rom_read_arbiter                                           |
// | Purpose  : Directed self-checking bench for rom_read_arbiter.            |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rom_read_arbiter;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [2:0]  req0_len = '0, req1_len = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_last, resp1_last, resp0_err, resp1_err;
  logic        rom_me, rom_oe;
  logic [10:0] rom_address;
  logic [31:0] rom_q = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  rom_read_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp0_last(resp0_last), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .resp1_last(resp1_last), .resp1_err(resp1_err),
    .rom_me(rom_me), .rom_oe(rom_oe), .rom_address(rom_address), .rom_q(rom_q)
  );

  // ROM word n holds 0xC0DE0000 + n; junk appears whenever no read was issued.
  always @(posedge clock) rom_q <= rom_me ? {16'hC0DE, 5'd0, rom_address} : 32'hDEAD_BEEF;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          hs_cyc[$];
  logic        hs_port[$];
  int          me_cyc[$];
  logic [10:0] me_addr[$];
  int          bt_cyc[$];
  logic [34:0] bt[$];
  int          occ = 0, viol = 0, stab_viol = 0, v0_cnt = 0, v1_cnt = 0;
  logic        prev_me = 1'b0, hold = 1'b0, hold_port = 1'b0, pop0, pop1;
  logic [31:0] hold_data = '0;

  always @(negedge clock) begin
    if (reset) begin
      occ = 0; prev_me = 1'b0; hold = 1'b0;
    end else begin
      pop0 = resp0_valid & resp0_ready;
      pop1 = resp1_valid & resp1_ready;
      if (req0_valid & req0_ready) begin hs_cyc.push_back(cyc); hs_port.push_back(1'b0); end
      if (req1_valid & req1_ready) begin hs_cyc.push_back(cyc); hs_port.push_back(1'b1); end
      if (rom_me) begin me_cyc.push_back(cyc); me_addr.push_back(rom_address); end
      if (pop0) begin bt_cyc.push_back(cyc); bt.push_back({1'b0, resp0_err, resp0_last, resp0_data}); end
      if (pop1) begin bt_cyc.push_back(cyc); bt.push_back({1'b1, resp1_err, resp1_last, resp1_data}); end
      if (resp0_valid) v0_cnt++;
      if (resp1_valid) v1_cnt++;
      if (rom_oe !== prev_me) viol++;
      if (rom_me && (int'(prev_me) + occ - int'(pop0 | pop1)) >= 2) viol++;
      if (hold && !(hold_port ? (resp1_valid && resp1_data == hold_data)
                              : (resp0_valid && resp0_data == hold_data))) stab_viol++;
      hold      = (resp0_valid & !resp0_ready) | (resp1_valid & !resp1_ready);
      hold_port = resp1_valid;
      hold_data = resp1_valid ? resp1_data : resp0_data;
      occ       = occ + int'(prev_me) - int'(pop0 | pop1);
      prev_me   = rom_me;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_logs();
    hs_cyc.delete(); hs_port.delete(); me_cyc.delete(); me_addr.delete();
    bt_cyc.delete(); bt.delete();
    viol = 0; stab_viol = 0; v0_cnt = 0; v1_cnt = 0;
  endtask

  // Pads logs with impossible values so indexing a short log reads garbage, not out of range.
  task automatic pad_logs(input int n);
    while (hs_port.size() < n) begin hs_port.push_back(1'bx); hs_cyc.push_back(-1000); end
    while (me_addr.size() < n) begin me_addr.push_back('x); me_cyc.push_back(-1000); end
    while (bt.size() < n) begin bt.push_back('x); bt_cyc.push_back(-1000); end
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 100 && hs_port.size() < n; i++) begin @(negedge clock); #1; end
    @(posedge clock); #1;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 100 && bt.size() < n; i++) tick(1);
    tick(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    @(negedge clock);
    n_checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_last, resp1_last,
         resp0_err, resp1_err, rom_me, rom_oe} !== 10'b0)
      $display("FAIL reset_outputs: got %b expected 0", {req0_ready, req1_ready, resp0_valid,
               resp1_valid, resp0_last, resp1_last, resp0_err, resp1_err, rom_me, rom_oe});
    else n_pass++;
    n_checks++;
    if (rom_address !== 11'd0) $display("FAIL reset_address: got %0d expected 0", rom_address);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    clear_logs();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_addr = BASE + 32'h10; req0_len = 3'd0; req0_valid = 1'b1;
    wait_hs(1);
    req0_valid = 1'b0;
    wait_beats(1);
    n_checks++;
    if ({me_addr.size(), bt.size()} !== {32'd1, 32'd1})
      $display("FAIL single_counts: got me=%0d beats=%0d expected 1/1", me_addr.size(), bt.size());
    else n_pass++;
    pad_logs(1);
    n_checks++;
    if (me_addr[0] !== 11'd4) $display("FAIL single_addr: got %0d expected 4", me_addr[0]);
    else n_pass++;
    n_checks++;
    if (me_cyc[0] - hs_cyc[0] !== 1)
      $display("FAIL single_me_latency: got %0d expected 1", me_cyc[0] - hs_cyc[0]);
    else n_pass++;
    n_checks++;
    if (bt_cyc[0] - me_cyc[0] !== 2)
      $display("FAIL single_resp_latency: got %0d expected 2", bt_cyc[0] - me_cyc[0]);
    else n_pass++;
    n_checks++;
    if (bt[0] !== {1'b0, 1'b0, 1'b1, 32'hC0DE_0004})
      $display("FAIL single_beat: got %h expected %h", bt[0], {1'b0, 1'b0, 1'b1, 32'hC0DE_0004});
    else n_pass++;
    n_checks++;
    if (v1_cnt !== 0) $display("FAIL single_port1_quiet: got %0d valid cycles expected 0", v1_cnt);
    else n_pass++;
  endtask

  task automatic test_burst_backpressure();
    clear_logs();
    resp1_ready = 1'b1;
    req1_addr = BASE; req1_len = 3'd7; req1_valid = 1'b1;
    wait_hs(1);
    req1_valid = 1'b0;
    for (int i = 0; i < 80 && bt.size() < 8; i++) begin resp1_ready = ~resp1_ready; tick(1); end
    resp1_ready = 1'b1;
    tick(3);
    n_checks++;
    if ({me_addr.size(), bt.size()} !== {32'd8, 32'd8})
      $display("FAIL bp_counts: got me=%0d beats=%0d expected 8/8", me_addr.size(), bt.size());
    else n_pass++;
    pad_logs(8);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bt[i] !== {1'b1, 1'b0, (i == 7), 32'hC0DE_0000 + 32'(i)})
        $display("FAIL bp_beat%0d: got %h expected %h", i, bt[i],
                 {1'b1, 1'b0, (i == 7), 32'hC0DE_0000 + 32'(i)});
      else n_pass++;
    end
    n_checks++;
    if ({viol, stab_viol, v0_cnt} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL bp_protocol: got issue_viol=%0d unstable=%0d port0_valid=%0d expected 0/0/0",
               viol, stab_viol, v0_cnt);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    clear_logs();
    reset = 1'b1; tick(2); reset = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_addr = BASE + 32'h20; req1_addr = BASE + 32'h40;
    req0_len = 3'd0; req1_len = 3'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_hs(4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_beats(4);
    n_checks++;
    if (hs_port.size() !== 4) $display("FAIL rr_count: got %0d expected 4", hs_port.size());
    else n_pass++;
    pad_logs(4);
    n_checks++;
    if ({hs_port[0], hs_port[1], hs_port[2], hs_port[3]} !== 4'b0101)
      $display("FAIL rr_order: got %b expected 0101",
               {hs_port[0], hs_port[1], hs_port[2], hs_port[3]});
    else n_pass++;
    n_checks++;
    if ({bt[0], bt[1]} !== {1'b0, 1'b0, 1'b1, 32'hC0DE_0008, 1'b1, 1'b0, 1'b1, 32'hC0DE_0010})
      $display("FAIL rr_data: got %h %h expected port0 C0DE0008 then port1 C0DE0010", bt[0], bt[1]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    clear_logs();
    req0_addr = BASE + 32'h1FF8; req0_len = 3'd3; req0_valid = 1'b1;
    wait_hs(1);
    req0_valid = 1'b0;
    wait_beats(4);
    pad_logs(4);
    n_checks++;
    if ({me_addr[0], me_addr[1], me_addr[2], me_addr[3]} !== {11'd2046, 11'd2047, 11'd0, 11'd1})
      $display("FAIL wrap_addr: got %0d %0d %0d %0d expected 2046 2047 0 1",
               me_addr[0], me_addr[1], me_addr[2], me_addr[3]);
    else n_pass++;
    n_checks++;
    if ({bt[1], bt[3]} !== {1'b0, 1'b0, 1'b0, 32'hC0DE_07FF, 1'b0, 1'b0, 1'b1, 32'hC0DE_0001})
      $display("FAIL wrap_data: got %h %h expected C0DE07FF then last C0DE0001", bt[1], bt[3]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_logs();
    req0_addr = BASE + 32'h100; req0_len = 3'd7; req0_valid = 1'b1;
    wait_hs(1);
    req0_valid = 1'b0;
    wait_beats(8);
    pad_logs(8);
    n_checks++;
    if (bt_cyc[0] - hs_cyc[0] !== 3)
      $display("FAIL b2b_first_latency: got %0d expected 3", bt_cyc[0] - hs_cyc[0]);
    else n_pass++;
    n_checks++;
    if (bt_cyc[7] - bt_cyc[0] !== 7)
      $display("FAIL b2b_throughput: got %0d cycles for 8 beats expected 7", bt_cyc[7] - bt_cyc[0]);
    else n_pass++;
    n_checks++;
    if (bt[7] !== {1'b0, 1'b0, 1'b1, 32'hC0DE_0047})
      $display("FAIL b2b_last_beat: got %h expected %h", bt[7], {1'b0, 1'b0, 1'b1, 32'hC0DE_0047});
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    clear_logs();
    req0_addr = BASE; req0_len = 3'd7; req0_valid = 1'b1;
    wait_hs(1);
    req0_valid = 1'b0;
    for (int i = 0; i < 40 && bt.size() < 2; i++) begin @(negedge clock); #1; end
    @(posedge clock); #1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    clear_logs();
    @(negedge clock);
    n_checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_last, resp1_last,
         resp0_err, resp1_err, rom_me, rom_oe, rom_address} !== 21'd0)
      $display("FAIL midreset_outputs: got %b expected all 0", {req0_ready, req1_ready,
               resp0_valid, resp1_valid, resp0_last, resp1_last, resp0_err, resp1_err,
               rom_me, rom_oe, rom_address});
    else n_pass++;
    tick(3);
    n_checks++;
    if ({v0_cnt, v1_cnt, me_addr.size()} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL midreset_flushed: got v0=%0d v1=%0d me=%0d expected 0/0/0",
               v0_cnt, v1_cnt, me_addr.size());
    else n_pass++;
    req1_addr = BASE + 32'h8; req1_len = 3'd0; req1_valid = 1'b1;
    wait_hs(1);
    req1_valid = 1'b0;
    wait_beats(1);
    n_checks++;
    if (bt.size() !== 1) $display("FAIL midreset_new_count: got %0d expected 1", bt.size());
    else n_pass++;
    pad_logs(1);
    n_checks++;
    if (bt[0] !== {1'b1, 1'b0, 1'b1, 32'hC0DE_0002})
      $display("FAIL midreset_new_beat: got %h expected %h", bt[0], {1'b1, 1'b0, 1'b1, 32'hC0DE_0002});
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    int          exp_me;
    logic [34:0] exp0, exp1;
`ifdef ROM_OOB_ERR_EN
    exp_me = 0;
    exp0   = {1'b0, 1'b1, 1'b0, 32'd0};
    exp1   = {1'b0, 1'b1, 1'b1, 32'd0};
`else
    exp_me = 2;
    exp0   = {1'b0, 1'b0, 1'b0, 32'hC0DE_0000};
    exp1   = {1'b0, 1'b0, 1'b1, 32'hC0DE_0001};
`endif
    clear_logs();
    req0_addr = BASE + 32'h2000; req0_len = 3'd1; req0_valid = 1'b1;
    wait_hs(1);
    req0_valid = 1'b0;
    wait_beats(2);
    n_checks++;
    if ({me_addr.size(), bt.size()} !== {exp_me, 32'd2})
      $display("FAIL oob_counts: got me=%0d beats=%0d expected %0d/2", me_addr.size(), bt.size(), exp_me);
    else n_pass++;
    pad_logs(2);
    n_checks++;
    if ({bt[0], bt[1]} !== {exp0, exp1})
      $display("FAIL oob_beats: got %h %h expected %h %h", bt[0], bt[1], exp0, exp1);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst_backpressure();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
